// File: rtl/binary_pkg.sv
// Shared encodings for binary_adapt: pixel threshold modes and frame-mean FSM states.
package binary_pkg;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_WIN   = 2'd1;
    localparam logic [1:0] MODE_ADAPT = 2'd2;
    localparam logic [1:0] MODE_INV   = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/binary_adapt_div.sv
// seq_div_u: restoring unsigned divider, one quotient bit per cycle MSB first, Q_W cycles from start.
// start restarts at any time, abort drops an active division; done pulses one cycle with quotient valid.
module seq_div_u #(
    parameter int DVD_W = 28,
    parameter int DVS_W = 20,
    parameter int Q_W   = 8
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int AW   = DVS_W + Q_W;
    localparam int CW   = (DVD_W > AW) ? DVD_W : AW;
    localparam int SC_W = $clog2(Q_W + 1);

    logic [CW-1:0]   rem_r, dsh_r, rem_src, dsh_src, rem_nxt;
    logic [Q_W-2:0]  q_src;
    logic            ge;
    logic [SC_W-1:0] step_cnt;

    // The start cycle already resolves the MSB, so the whole quotient takes exactly Q_W cycles.
    always_comb begin
        rem_src = start ? CW'(dividend) : rem_r;
        dsh_src = start ? (CW'(divisor) << (Q_W - 1)) : dsh_r;
        q_src   = start ? '0 : quotient[Q_W-2:0];
        ge      = (rem_src >= dsh_src);
        rem_nxt = ge ? (rem_src - dsh_src) : rem_src;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rem_r    <= '0;
            dsh_r    <= '0;
            quotient <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_r    <= rem_nxt;
                dsh_r    <= dsh_src >> 1;
                quotient <= {q_src, ge};
                step_cnt <= SC_W'(Q_W - 1);
                busy     <= 1'b1;
            end else if (abort) begin
                busy <= 1'b0;
            end else if (busy) begin
                rem_r    <= rem_nxt;
                dsh_r    <= dsh_src >> 1;
                quotient <= {q_src, ge};
                step_cnt <= step_cnt - SC_W'(1);
                if (step_cnt == SC_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/binary_adapt.sv
// binary_adapt: grey->FG/BG pixel binariser (fixed/window/inverted/adaptive), 1-cycle pixel+sync latency,
// streaming with no backpressure; frame mean divided in blanking. Define BINARY_HYST_EN for per-line hysteresis.
module binary_adapt
    import binary_pkg::*;
#(
    parameter int          GRAY_W   = 8,
    parameter int          OUT_W    = 16,
    parameter logic [15:0] FG_VAL   = 16'hFFFF,
    parameter logic [15:0] BG_VAL   = 16'h0000,
    parameter int          THR_INIT = 64,
    parameter int          CNT_W    = 20,
    parameter bit          VS_POL   = 1'b1
`ifdef BINARY_HYST_EN
    ,
    parameter int          HYST     = 4
`endif
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [GRAY_W-1:0] thr_cfg,
    input  logic [GRAY_W-1:0] thr_hi,
    input  logic [GRAY_W:0]   thr_ofs,
    input  logic [GRAY_W-1:0] data_gray,
    input  logic              de_gray,
    input  logic              hsync_gray,
    input  logic              vsync_gray,
    output logic [OUT_W-1:0]  data_bin,
    output logic              de_bin,
    output logic              hsync_bin,
    output logic              vsync_bin,
    output logic [GRAY_W-1:0] mean_frame,
    output logic              mean_vld
);

    localparam int                SUM_W   = GRAY_W + CNT_W;
    localparam logic [OUT_W-1:0]  FG_O    = OUT_W'(FG_VAL);
    localparam logic [OUT_W-1:0]  BG_O    = OUT_W'(BG_VAL);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [1:0]        mode_sh;
    logic [GRAY_W-1:0] thr_cfg_sh, thr_hi_sh, thr_act, thr_sel, thr_new;
    logic [GRAY_W:0]   thr_ofs_sh;
    logic [SUM_W-1:0]  sum_acc;
    logic [CNT_W-1:0]  cnt_acc;
    logic [1:0]        state;
    logic              frame_bnd, cmp_fg, win_fg, pix_fg;
    logic              div_start, div_abort, div_busy, div_done;
    logic [GRAY_W-1:0] div_q;
    logic signed [GRAY_W+1:0] thr_sum;

    // vsync_bin doubles as the registered vsync sample.
    assign frame_bnd = (vsync_gray == VS_POL) && (vsync_bin != VS_POL);

    assign thr_sel = (mode_sh == MODE_ADAPT) ? thr_act : thr_cfg_sh;
    assign win_fg  = (data_gray > thr_cfg_sh) && (data_gray <= thr_hi_sh);

`ifdef BINARY_HYST_EN
    logic              hyst_q, hyst_cur;
    logic [GRAY_W:0]   thr_up_w;
    logic [GRAY_W-1:0] thr_up, thr_dn;

    assign thr_up_w = {1'b0, thr_sel} + (GRAY_W+1)'(HYST);
    assign thr_up   = thr_up_w[GRAY_W] ? '1 : thr_up_w[GRAY_W-1:0];
    assign thr_dn   = (thr_sel >= GRAY_W'(HYST)) ? (thr_sel - GRAY_W'(HYST)) : '0;
    assign hyst_cur = (de_gray && !de_bin) ? 1'b0 : hyst_q;
    assign cmp_fg   = hyst_cur ? (data_gray > thr_dn) : (data_gray > thr_up);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            hyst_q <= 1'b0;
        else if (de_gray && mode_sh != MODE_WIN)
            hyst_q <= cmp_fg;
    end
`else
    assign cmp_fg = (data_gray > thr_sel);
`endif

    always_comb begin
        pix_fg = cmp_fg;
        if (mode_sh == MODE_WIN)
            pix_fg = win_fg;
        else if (mode_sh == MODE_INV)
            pix_fg = !cmp_fg;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            data_bin  <= '0;
            de_bin    <= 1'b0;
            hsync_bin <= 1'b0;
            vsync_bin <= 1'b0;
        end else begin
            data_bin  <= (de_gray && pix_fg) ? FG_O : BG_O;
            de_bin    <= de_gray;
            hsync_bin <= hsync_gray;
            vsync_bin <= vsync_gray;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            mode_sh    <= MODE_FIXED;
            thr_cfg_sh <= '0;
            thr_hi_sh  <= '0;
            thr_ofs_sh <= '0;
        end else if (frame_bnd) begin
            mode_sh    <= mode;
            thr_cfg_sh <= thr_cfg;
            thr_hi_sh  <= thr_hi;
            thr_ofs_sh <= thr_ofs;
        end
    end

    // The pixel on the boundary cycle opens the new frame's sums.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sum_acc <= '0;
            cnt_acc <= '0;
        end else if (frame_bnd) begin
            sum_acc <= de_gray ? SUM_W'(data_gray) : '0;
            cnt_acc <= de_gray ? CNT_W'(1) : '0;
        end else if (de_gray && cnt_acc != CNT_MAX) begin
            sum_acc <= sum_acc + SUM_W'(data_gray);
            cnt_acc <= cnt_acc + CNT_W'(1);
        end
    end

    always_comb begin
        div_start = 1'b0;
        div_abort = 1'b0;
        if (frame_bnd && state != ST_IDLE) begin
            if (cnt_acc != '0)
                div_start = 1'b1;
            else if (div_busy)
                div_abort = 1'b1;
        end
    end

    seq_div_u #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W),
        .Q_W   (GRAY_W)
    ) u_div (
        .pclk     (pclk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (sum_acc),
        .divisor  (cnt_acc),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // Two guard bits hold the full range of mean + signed offset before clamping.
    assign thr_sum = $signed({2'b00, div_q}) + $signed({thr_ofs_sh[GRAY_W], thr_ofs_sh});

    always_comb begin
        if (thr_sum[GRAY_W+1])
            thr_new = '0;
        else if (thr_sum[GRAY_W])
            thr_new = '1;
        else
            thr_new = thr_sum[GRAY_W-1:0];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mean_frame <= '0;
            mean_vld   <= 1'b0;
            thr_act    <= GRAY_W'(THR_INIT);
        end else begin
            mean_vld <= 1'b0;
            case (state)
                ST_IDLE:  if (frame_bnd) state <= ST_ACCUM;
                ST_ACCUM: if (div_start) state <= ST_DIV;
                ST_DIV: begin
                    if (frame_bnd)
                        state <= div_start ? ST_DIV : ST_ACCUM;
                    else if (div_done)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    mean_frame <= div_q;
                    mean_vld   <= 1'b1;
                    thr_act    <= thr_new;
                    state      <= div_start ? ST_DIV : ST_ACCUM;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_adapt.sv
// Directed-vector bench for binary_adapt in the default build.
module tb_binary_adapt;

    logic        pclk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  thr_cfg, thr_hi;
    logic [8:0]  thr_ofs;
    logic [7:0]  data_gray;
    logic        de_gray, hsync_gray, vsync_gray;
    logic [15:0] data_bin;
    logic        de_bin, hsync_bin, vsync_bin;
    logic [7:0]  mean_frame;
    logic        mean_vld;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    binary_adapt dut (
        .pclk       (pclk),
        .rst        (rst),
        .mode       (mode),
        .thr_cfg    (thr_cfg),
        .thr_hi     (thr_hi),
        .thr_ofs    (thr_ofs),
        .data_gray  (data_gray),
        .de_gray    (de_gray),
        .hsync_gray (hsync_gray),
        .vsync_gray (vsync_gray),
        .data_bin   (data_bin),
        .de_bin     (de_bin),
        .hsync_bin  (hsync_bin),
        .vsync_bin  (vsync_bin),
        .mean_frame (mean_frame),
        .mean_vld   (mean_vld)
    );

    task automatic cyc(input logic [7:0] p, input logic d, input logic h, input logic v);
        data_gray  = p;
        de_gray    = d;
        hsync_gray = h;
        vsync_gray = v;
        @(posedge pclk);
        #1;
    endtask

    task automatic blank(input int n);
        repeat (n) cyc(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse;
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_mean(input int n, output int pulses, output logic [7:0] mval);
        pulses = 0;
        mval   = 8'd0;
        for (int i = 0; i < n; i++) begin
            cyc(8'd0, 1'b0, 1'b0, 1'b0);
            if (mean_vld === 1'b1) begin
                pulses++;
                mval = mean_frame;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 2'd0; thr_cfg = 8'd0; thr_hi = 8'd0; thr_ofs = 9'd0;
        data_gray = 8'd255; de_gray = 1'b1; hsync_gray = 1'b1; vsync_gray = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", data_bin); end
        checks++; if ({de_bin, hsync_bin, vsync_bin, mean_vld} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags got %b exp 0000", {de_bin, hsync_bin, vsync_bin, mean_vld}); end
        checks++; if (mean_frame !== 8'd0) begin errors++; $display("FAIL rst_mean got %0d exp 0", mean_frame); end
        data_gray = 8'd0; de_gray = 1'b0; hsync_gray = 1'b0; vsync_gray = 1'b0;
        #2;
        rst = 1'b0;
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fixed;
        mode = 2'd0; thr_cfg = 8'd64;
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (vsync_bin !== 1'b1) begin errors++; $display("FAIL fix_vs_hi got %b exp 1", vsync_bin); end
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (vsync_bin !== 1'b0) begin errors++; $display("FAIL fix_vs_lo got %b exp 0", vsync_bin); end
        cyc(8'd63, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL fix_63 got %h exp 0000", data_bin); end
        checks++; if (de_bin !== 1'b1) begin errors++; $display("FAIL fix_de got %b exp 1", de_bin); end
        cyc(8'd64, 1'b1, 1'b1, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL fix_64 got %h exp 0000", data_bin); end
        checks++; if (hsync_bin !== 1'b1) begin errors++; $display("FAIL fix_hs got %b exp 1", hsync_bin); end
        data_gray = 8'd65; hsync_gray = 1'b0;
        #1;
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL fix_lat0 got %h exp 0000", data_bin); end
        cyc(8'd65, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL fix_65 got %h exp ffff", data_bin); end
        cyc(8'd200, 1'b0, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL fix_de0 got %h exp 0000", data_bin); end
    endtask

    task automatic test_window;
        logic [7:0]  px1 [4] = '{8'd50, 8'd51, 8'd100, 8'd101};
        logic [15:0] ex1 [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [7:0]  px2 [4] = '{8'd50, 8'd75, 8'd100, 8'd101};
        mode = 2'd1; thr_cfg = 8'd50; thr_hi = 8'd100;
        vs_pulse(); blank(12);
        for (int i = 0; i < 4; i++) begin
            cyc(px1[i], 1'b1, 1'b0, 1'b0);
            checks++; if (data_bin !== ex1[i]) begin errors++;
                $display("FAIL win_%0d got %h exp %h", px1[i], data_bin, ex1[i]); end
        end
        thr_cfg = 8'd100; thr_hi = 8'd50;
        vs_pulse(); blank(12);
        for (int i = 0; i < 4; i++) begin
            cyc(px2[i], 1'b1, 1'b0, 1'b0);
            checks++; if (data_bin !== 16'h0000) begin errors++;
                $display("FAIL win_inv_%0d got %h exp 0000", px2[i], data_bin); end
        end
    endtask

    task automatic test_adapt;
        int         np;
        logic [7:0] mv;
        mode = 2'd2; thr_ofs = 9'd0;
        vs_pulse(); blank(12);
        repeat (16) cyc(8'd200, 1'b1, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        wait_mean(20, np, mv);
        checks++; if (np !== 1) begin errors++; $display("FAIL adapt_pulses got %0d exp 1", np); end
        checks++; if (mv !== 8'd200) begin errors++; $display("FAIL adapt_mean got %0d exp 200", mv); end
        cyc(8'd200, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL adapt_200 got %h exp 0000", data_bin); end
        cyc(8'd201, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL adapt_201 got %h exp ffff", data_bin); end
        thr_ofs = 9'd80;
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        wait_mean(20, np, mv);
        checks++; if (np !== 1 || mv !== 8'd200) begin errors++;
            $display("FAIL clamp_mean got %0d pulses mean %0d exp 1 pulse mean 200", np, mv); end
        cyc(8'd255, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL clamp_255 got %h exp 0000", data_bin); end
        cyc(8'd250, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL clamp_250 got %h exp 0000", data_bin); end
    endtask

    task automatic test_mode_change;
        mode = 2'd0; thr_cfg = 8'd64; thr_ofs = 9'd0;
        vs_pulse(); blank(12);
        cyc(8'd65, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL mc_pre got %h exp ffff", data_bin); end
        mode = 2'd3;
        cyc(8'd65, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL mc_mid65 got %h exp ffff", data_bin); end
        cyc(8'd63, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL mc_mid63 got %h exp 0000", data_bin); end
        vs_pulse();
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL inv_blank got %h exp 0000", data_bin); end
        blank(12);
        cyc(8'd65, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL inv_65 got %h exp 0000", data_bin); end
        cyc(8'd63, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL inv_63 got %h exp ffff", data_bin); end
    endtask

    task automatic test_abort;
        int         np, pre;
        logic [7:0] mv;
        mode = 2'd2; thr_ofs = 9'd0;
        vs_pulse(); blank(12);
        repeat (4) cyc(8'd100, 1'b1, 1'b0, 1'b0);
        pre = 0;
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        cyc(8'd80, 1'b1, 1'b0, 1'b0);
        if (mean_vld === 1'b1) pre++;
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL abort_80 got %h exp ffff", data_bin); end
        cyc(8'd90, 1'b1, 1'b0, 1'b0);
        if (mean_vld === 1'b1) pre++;
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        if (mean_vld === 1'b1) pre++;
        wait_mean(20, np, mv);
        checks++; if (pre + np !== 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", pre + np); end
        checks++; if (mv !== 8'd85) begin errors++; $display("FAIL abort_mean got %0d exp 85", mv); end
        cyc(8'd85, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL abort_85 got %h exp 0000", data_bin); end
        cyc(8'd86, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL abort_86 got %h exp ffff", data_bin); end
    endtask

    task automatic test_reset_mid;
        int         np;
        logic [7:0] mv;
        cyc(8'd200, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        checks++; if (data_bin !== 16'h0000 || de_bin !== 1'b0) begin errors++;
            $display("FAIL rstmid_out got %h/%b exp 0000/0", data_bin, de_bin); end
        checks++; if (mean_frame !== 8'd0) begin errors++; $display("FAIL rstmid_mean got %0d exp 0", mean_frame); end
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        mode = 2'd2; thr_ofs = 9'd0;
        cyc(8'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL rst_shadow_1 got %h exp ffff", data_bin); end
        cyc(8'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL rst_shadow_0 got %h exp 0000", data_bin); end
        vs_pulse(); blank(12);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        wait_mean(20, np, mv);
        checks++; if (np !== 0) begin errors++; $display("FAIL empty_frame pulses got %0d exp 0", np); end
        cyc(8'd64, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'h0000) begin errors++; $display("FAIL rst_thr_64 got %h exp 0000", data_bin); end
        cyc(8'd65, 1'b1, 1'b0, 1'b0);
        checks++; if (data_bin !== 16'hFFFF) begin errors++; $display("FAIL rst_thr_65 got %h exp ffff", data_bin); end
        checks++; if (mean_frame !== 8'd0) begin errors++; $display("FAIL rst_mean_kept got %0d exp 0", mean_frame); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_window();
        test_adapt();
        test_mode_change();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_adapt.md
Name: binary_adapt

Overview:
- Parametrised successor to the fixed-threshold binariser; sits between the grey-conversion stage and the VGA/display or morphology stages.
- Converts each grey pixel to a foreground/background output word.
- Modes: fixed threshold, window threshold, inverted fixed, and adaptive threshold. In adaptive mode the threshold is the previous frame's mean luminance plus a signed offset.
- The frame mean is computed during vertical blanking by a sequential divider.

Parameters:
- GRAY_W, 8, grey pixel width
- OUT_W, 16, output pixel width
- FG_VAL, 16'hFFFF, output word for foreground (truncated/extended to OUT_W)
- BG_VAL, 16'h0000, output word for background
- THR_INIT, 64, adaptive threshold after reset
- CNT_W, 20, pixel-count width (max 2^CNT_W-1 active pixels per frame)
- VS_POL, 1, vsync active level; frame boundary = transition into the active level

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0=fixed, 1=window, 2=adaptive, 3=inverted fixed
- thr_cfg  in  GRAY_W  fixed threshold, and window low bound
- thr_hi  in  GRAY_W  window high bound
- thr_ofs  in  GRAY_W+1  signed offset added to frame mean (adaptive)
- data_gray  in  GRAY_W  grey pixel
- de_gray  in  1  pixel valid (active video)
- hsync_gray  in  1  line sync
- vsync_gray  in  1  frame sync
- data_bin  out  OUT_W  binarised pixel
- de_bin  out  1  de delayed to match data_bin
- hsync_bin  out  1  hsync delayed to match data_bin
- vsync_bin  out  1  vsync delayed to match data_bin
- mean_frame  out  GRAY_W  last computed frame mean
- mean_vld  out  1  one-cycle pulse when mean_frame updates

Behaviour:
- Reset: all outputs 0; thr_act=THR_INIT; shadow cfg = mode 0, thr 0; accumulators 0; FSM IDLE.
- Latency: data_bin, de_bin, hsync_bin, vsync_bin all 1 cycle after their inputs (single register stage).
- Compare: FG when pix > thr; equal → BG.
  - mode 0: thr = thr_cfg.
  - mode 3: result inverted.
  - mode 1: FG iff thr_cfg < pix <= thr_hi; if thr_cfg >= thr_hi, all BG.
  - mode 2: thr = thr_act.
- de_gray=0 → data_bin=BG_VAL regardless of mode.
- Config shadowing: mode, thr_cfg, thr_hi and thr_ofs are latched only on the frame-boundary cycle, so a mid-frame change takes effect from the next frame.
- Frame boundary: vsync_gray registered; boundary when the previous sample is !VS_POL and the current sample is VS_POL.
- Accumulation: in every mode, while de_gray=1, sum += pix and cnt += 1.
  - sum width = GRAY_W+CNT_W.
  - cnt saturates at all-ones; sum stops accumulating once cnt saturates.
- FSM:
  - IDLE→ACCUM after the first boundary following reset.
  - ACCUM: at boundary, latch sum/cnt into divider registers and clear the accumulators in the same cycle (the pixel on that cycle is counted in the new frame). Go to DIV if cnt≠0; otherwise stay in ACCUM with no update.
  - DIV: restoring division, one quotient bit per cycle, MSB first, exactly GRAY_W cycles. Quotient is the floor mean (always < 2^GRAY_W).
  - DONE (1 cycle): mean_frame ← q; mean_vld=1; thr_act ← clamp(q + thr_ofs_shadow, 0, 2^GRAY_W-1), using a signed GRAY_W+2-bit intermediate. Return to ACCUM.
- Boundary arriving while in DIV: abort the division with no update (mean_frame and thr_act kept), latch the new sum/cnt, restart DIV. The accumulators restart as normal.
- thr_act changes only in DONE, which occurs during blanking for any frame ≥ GRAY_W+2 blanking cycles.
- rst asserted mid-operation: immediate return to the reset state; any partial frame is discarded.

Optional Feature:
- Macro: BINARY_HYST_EN.
- Defined:
  - Adds parameter HYST (default 4).
  - Modes 0, 2 and 3 use a per-line hysteresis state:
    - from BG → FG when pix > thr+HYST (saturated at max);
    - from FG → BG when pix <= thr-HYST (floored at 0).
  - The state resets to BG on each de_gray rising edge.
  - Mode 1 is unaffected.
  - Output latency is unchanged (still 1 cycle).
- Undefined: plain single compare; no HYST parameter; no hysteresis register.

Decomposition:
- Shared package binary_pkg holds:
  - mode encodings MODE_FIXED=0, MODE_WIN=1, MODE_ADAPT=2, MODE_INV=3;
  - FSM state encodings IDLE/ACCUM/DIV/DONE.
- One sub-module: seq_div_u, a restoring unsigned divider.
  - Parameters: dividend width, divisor width, quotient width.
  - Signals: start/abort/busy/done.

Test Plan:
- Mode 0, thr_cfg=64: pixels 63, 64, 65 with de=1 → BG, BG, FG (0x0000, 0x0000, 0xFFFF), each one cycle later; syncs delayed 1 cycle.
- Mode 1, thr_cfg=50, thr_hi=100: pixels 50, 51, 100, 101 → BG, FG, FG, BG. Then thr_cfg=100, thr_hi=50 → all BG.
- Mode 2, thr_ofs=0:
  - frame of 16 pixels all 200 → mean_vld pulse, mean_frame=200, thr_act=200; next frame pixel 200 → BG, 201 → FG.
  - thr_ofs=+80 on the same data → thr_act clamps to 255.
- Mode change mid-frame (0→3) → no effect until the next vsync boundary; after it, pixel 65 with thr 64 → BG.
- Boundary issued 3 cycles after the previous boundary (during DIV) → no mean_vld and thr_act unchanged; the following divide completes with the correct mean.
- rst pulse mid-frame → outputs 0 and thr_act=64 immediately; the next frame with zero de cycles → no mean_vld.
